// File: rtl/seg7_scan_driver.sv
// ============================================================================
//  seg7_scan_driver : 8-digit common-anode 7-segment scanner, one hex digit
//  per slot, word snapshotted once per frame. Optional SEG7_LZB_EN macro
//  enables leading-zero blanking.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
    parameter int CLK_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    output logic [7:0]  SEG,
    output logic [7:0]  AN,
    output logic        frame_done
);

    localparam int              PW          = $clog2(CLK_DIV);
    localparam logic [PW-1:0]   C_PRESC_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SCAN  = 1'b1
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [2:0]    r_digit;
    logic [31:0]   r_shadow;

    state_t        w_state_nxt;
    logic [PW-1:0] w_presc_nxt;
    logic [2:0]    w_digit_nxt;
    logic [31:0]   w_shadow_nxt;
    logic          w_fd_nxt;
    logic          w_tick;
    logic [7:0]    w_an_nxt;
    logic [7:0]    w_seg_nxt;
`ifdef SEG7_LZB_EN
    logic [2:0]    w_msd;
`endif

    // Full segment byte {dp, gfedcba}, active-low, dp always off.
    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    always_comb begin
        w_tick       = (r_presc == C_PRESC_MAX);
        w_presc_nxt  = w_tick ? '0 : r_presc + PW'(1);
        w_state_nxt  = r_state;
        w_digit_nxt  = r_digit;
        w_shadow_nxt = r_shadow;
        w_fd_nxt     = 1'b0;

        case (r_state)
            ST_BLANK: begin
                if (w_tick) begin
                    w_shadow_nxt = data_in;
                    w_digit_nxt  = 3'd0;
                    w_fd_nxt     = 1'b1;
                    w_state_nxt  = ST_SCAN;
                end
            end
            default: begin
                if (w_tick) begin
                    if (r_digit == 3'd7) begin
                        w_shadow_nxt = data_in;
                        w_digit_nxt  = 3'd0;
                        w_fd_nxt     = 1'b1;
                    end else begin
                        w_digit_nxt  = r_digit + 3'd1;
                    end
                end
            end
        endcase

        // Outputs are derived from next-state values so they change on the tick edge.
        if (w_state_nxt == ST_BLANK) begin
            w_an_nxt  = 8'hFF;
            w_seg_nxt = 8'hFF;
        end else begin
            w_an_nxt  = ~(8'b1 << w_digit_nxt);
            w_seg_nxt = hex7(w_shadow_nxt[{w_digit_nxt, 2'b00} +: 4]);
        end

`ifdef SEG7_LZB_EN
        w_msd = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (w_shadow_nxt[4*k +: 4] != 4'h0) begin
                w_msd = 3'(k);
            end
        end
        if (w_digit_nxt > w_msd) begin
            w_an_nxt  = 8'hFF;
            w_seg_nxt = 8'hFF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc    <= '0;
            r_state    <= ST_BLANK;
            r_digit    <= 3'd0;
            r_shadow   <= 32'd0;
            AN         <= 8'hFF;
            SEG        <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            r_presc    <= w_presc_nxt;
            r_state    <= w_state_nxt;
            r_digit    <= w_digit_nxt;
            r_shadow   <= w_shadow_nxt;
            AN         <= w_an_nxt;
            SEG        <= w_seg_nxt;
            frame_done <= w_fd_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
//  tb_seg7_scan_driver : directed bench for seg7_scan_driver with CLK_DIV=4.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic [7:0]  SEG;
    logic [7:0]  AN;
    logic        frame_done;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] drive;
        logic [7:0]  an;
        logic [7:0]  seg;
    } vec_t;

    vec_t vec [16];

    seg7_scan_driver #(.CLK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .SEG        (SEG),
        .AN         (AN),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reset, snapshot d at the first tick, then walk one full frame.
    task automatic run_frame(input string name, input logic [31:0] d,
                             input logic [63:0] ean, input logic [63:0] eseg);
        rst = 1'b1;
        step();
        rst     = 1'b0;
        data_in = d;
        repeat (4) step();
        chk({name, "_fd"}, {7'd0, frame_done}, 8'h01);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_an%0d", name, k), AN, ean[8*k +: 8]);
            chk($sformatf("%s_seg%0d", name, k), SEG, eseg[8*k +: 8]);
            repeat (4) step();
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        data_in = 32'h0;

        vec[0] = '{32'h1234_ABCD, 8'hFE, 8'hA1};
        vec[1] = '{32'h1234_ABCD, 8'hFD, 8'hC6};
        vec[2] = '{32'h1234_ABCD, 8'hFB, 8'h83};
        vec[3] = '{32'hFFFF_FFFF, 8'hF7, 8'h88};
        vec[4] = '{32'hFFFF_FFFF, 8'hEF, 8'h99};
        vec[5] = '{32'hFFFF_FFFF, 8'hDF, 8'hB0};
        vec[6] = '{32'hFFFF_FFFF, 8'hBF, 8'hA4};
        vec[7] = '{32'hFFFF_FFFF, 8'h7F, 8'hF9};
        for (int k = 8; k < 16; k++) begin
            vec[k] = '{32'hFFFF_FFFF, vec[k-8].an, 8'h8E};
        end

        // Reset state
        step();
        step();
        chk("rst_an", AN, 8'hFF);
        chk("rst_seg", SEG, 8'hFF);
        chk("rst_fd", {7'd0, frame_done}, 8'h00);

        // First tick after reset release
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("blank_an_c%0d", i), AN, 8'hFF);
            chk($sformatf("blank_seg_c%0d", i), SEG, 8'hFF);
        end
        step();
        chk("first_an", AN, 8'hFE);
        chk("first_seg", SEG, 8'hC0);
        chk("first_fd", {7'd0, frame_done}, 8'h01);
        step();
        chk("first_fd_drop", {7'd0, frame_done}, 8'h00);

        // Two frames from the table; data changes while digit 3 is shown
        rst = 1'b1;
        step();
        rst     = 1'b0;
        data_in = 32'h1234_ABCD;
        repeat (4) step();
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("tbl%0d_an", k), AN, vec[k].an);
            chk($sformatf("tbl%0d_seg", k), SEG, vec[k].seg);
            chk($sformatf("tbl%0d_fd", k), {7'd0, frame_done},
                ((k % 8) == 0) ? 8'h01 : 8'h00);
            data_in = vec[k].drive;
            for (int j = 0; j < 3; j++) begin
                step();
                chk($sformatf("tbl%0d_hold_an", k), AN, vec[k].an);
                chk($sformatf("tbl%0d_hold_fd", k), {7'd0, frame_done}, 8'h00);
            end
            step();
        end

        // Reset mid-frame at digit 5
        repeat (20) step();
        chk("mid_d5_an", AN, 8'hDF);
        chk("mid_d5_seg", SEG, 8'h8E);
        rst = 1'b1;
        step();
        chk("mid_rst_an", AN, 8'hFF);
        chk("mid_rst_seg", SEG, 8'hFF);
        chk("mid_rst_fd", {7'd0, frame_done}, 8'h00);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("mid_restart_an_c%0d", i), AN, 8'hFF);
        end
        step();
        chk("mid_restart_an", AN, 8'hFE);
        chk("mid_restart_seg", SEG, 8'h8E);
        chk("mid_restart_fd", {7'd0, frame_done}, 8'h01);

        // Reset asserted in the tick cycle: reset must win
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("tickrst_an", AN, 8'hFF);
        chk("tickrst_seg", SEG, 8'hFF);
        chk("tickrst_fd", {7'd0, frame_done}, 8'h00);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("tickrst_an_c%0d", i), AN, 8'hFF);
        end
        step();
        chk("tickrst_first_an", AN, 8'hFE);
        chk("tickrst_first_fd", {7'd0, frame_done}, 8'h01);

        // Leading-zero behaviour
`ifdef SEG7_LZB_EN
        run_frame("lzb_a5", 32'h0000_00A5,
                  64'hFFFF_FFFF_FFFF_FDFE, 64'hFFFF_FFFF_FFFF_8892);
        run_frame("lzb_zero", 32'h0000_0000,
                  64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFC0);
`else
        run_frame("nolzb_a5", 32'h0000_00A5,
                  64'h7FBF_DFEF_F7FB_FDFE, 64'hC0C0_C0C0_C0C0_8892);
        run_frame("nolzb_zero", 32'h0000_0000,
                  64'h7FBF_DFEF_F7FB_FDFE, 64'hC0C0_C0C0_C0C0_C0C0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
